load_byte_assembler: RTL and testbench
======================================

# load_byte_assembler

Upstream neighbour of the sign-extension stage in the load path. On a load request it reads 1, 2 or 4 consecutive bytes from the byte-wide data RAM, one byte per request/acknowledge handshake. It assembles the bytes big-endian into a right-justified, zero-filled 32-bit word and presents that word on `D`, which feeds `signExtension`'s data input directly. The shared `dataSize` encoding drives both blocks.

## Interface
- `ADDR_W`, default 8: width of the RAM byte address.

- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `START`  in  1  load request; sampled only in IDLE.
- `ADDR`  in  ADDR_W  byte address of the first (most significant) byte.
- `dataSize`  in  2  load size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- `BUSY`  out  1  high from the cycle after an accepted START until the DONE cycle, inclusive.
- `DONE`  out  1  one-cycle pulse; `D` is valid from this cycle onward.
- `ERR`  out  1  one-cycle pulse on a misaligned request.
- `D`  out  32  assembled data, zero-extended; holds its value until the next completion.
- `MEM_ADDR`  out  ADDR_W  current byte address to the RAM.
- `MEM_REQ`  out  1  read request to the RAM.
- `MEM_DATA`  in  8  RAM read byte; valid when `MEM_ACK` is high.
- `MEM_ACK`  in  1  RAM completion strobe.

## Operation
- **States:** IDLE, REQ, GAP, FIN.
- **IDLE, START=1, aligned request:**
  - Latch `ADDR` into `MEM_ADDR`.
  - Latch the byte count N: 1 for byte, 2 for halfword, 4 for 10/11.
  - Clear the shift register and go to REQ.
- **IDLE, START=1, misaligned request:** misaligned means halfword with `ADDR[0]`=1, or word with `ADDR[1:0]`≠0.
  - Pulse `ERR` for the next cycle and stay in IDLE.
  - No memory access; `D` is unchanged.
- **REQ:**
  - `MEM_REQ`=1 and `MEM_ADDR` is held.
  - On a cycle with `MEM_ACK`=1, shift in the byte: shift ← {shift[23:0], `MEM_DATA`}, and increment the count.
  - If the count reaches N, go to FIN. Otherwise go to GAP.
- **GAP:** `MEM_REQ`=0 for exactly one cycle; `MEM_ADDR` increments by 1 (modulo 2^ADDR_W, wrapping at the top), then go to REQ.
- **FIN:** `D` ← shift, `DONE`=1 for one cycle, then go to IDLE.
- **Results:**
  - byte → {24'h0, b0}
  - halfword → {16'h0, b0, b1}
  - word → {b0, b1, b2, b3}, where b0 is the byte at `ADDR`.
- `START` is ignored whenever the block is not in IDLE.
- `MEM_ACK` is ignored outside REQ.
- `RST` overrides every other input in the same cycle.

## Timing
- **Reset values:**
  - State IDLE.
  - `BUSY`, `DONE`, `ERR` and `MEM_REQ` = 0.
  - `D` = 32'h0 and `MEM_ADDR` = 0.
- **Reset mid-transaction:** `MEM_REQ` falls at the reset edge and no `DONE` is produced.
- **Zero-wait memory** (`MEM_ACK` high in the first REQ cycle), with START accepted at edge 0:
  - `DONE` is high in cycle 2N.
  - byte: cycle 2; halfword: cycle 4; word: cycle 8.
- **Wait states:** each wait cycle on a byte extends `DONE` by one cycle; `MEM_ADDR` and `MEM_REQ` stay stable throughout.
- **ERR timing:** `ERR` is high in cycle 1 after the misaligned START.
- **Back-to-back requests:** the earliest next START is accepted in the cycle after FIN.
- **D stability:** `D` changes only on the edge into FIN and on reset, so the downstream `signExtension` sees a stable input while its enable is asserted.

## Structure
- The shared load-path package holds:
  - the `dataSize` constants: SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, SIZE_DWORD=2'b11;
  - the state encoding constants for IDLE, REQ, GAP and FIN.
- `signExtension` uses the same `dataSize` constants.
- Single module; no sub-module. Shifting and counting stay inline. The byte counter is 3 bits.

## Test plan
All scenarios use a RAM model holding 0x10:F0, 0x11:E4, 0x12:74, 0x13:92, with zero-wait ACK unless stated.
- **Zero-wait word:** START, word, `ADDR`=0x10.
  - `MEM_ADDR` steps 10,11,12,13, with `MEM_REQ` low for one cycle between bytes.
  - `DONE` in cycle 8 and `D`=F0E47492.
- **Byte and halfword:**
  - byte at 0x13 → `D`=00000092 at cycle 2.
  - halfword at 0x12 → `D`=00007492 at cycle 4.
  - Chaining `D` into `signExtension` gives FFFFFF92 and 00007492 respectively.
- **Misaligned requests:** halfword at 0x11, then word at 0x12.
  - Each produces an `ERR` pulse in cycle 1.
  - `MEM_REQ` never rises and `D` keeps its prior value.
- **Wait states:** word at 0x10 with `MEM_ACK` delayed 3 cycles per byte.
  - `DONE` in cycle 20 and `D`=F0E47492.
  - `MEM_ADDR` stable during each wait.
  - A START pulsed while `BUSY` is ignored.
- **Reset mid-word:** assert `RST` after 2 bytes are acknowledged.
  - Next cycle: `MEM_REQ`=0, `BUSY`=0, `D`=0, no `DONE`.
  - A following byte load at 0x10 returns 000000F0.

Source files
------------

// File: rtl/load_byte_assembler_pkg.sv
// Shared load-path definitions: dataSize encoding (also used by signExtension)
// and the assembler state encoding.
package load_byte_assembler_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HALF  = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_DWORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_GAP  = 2'b10,
        ST_FIN  = 2'b11
    } state_e;

    // Byte count for a load; the 11 encoding behaves as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = addr_lo[0];
            default:   is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_byte_assembler.sv
// Reads 1/2/4 bytes from a byte-wide RAM, one handshake per byte, and assembles
// them big-endian into a right-justified, zero-filled 32-bit word on D.
module load_byte_assembler
    import load_byte_assembler_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [1:0]        dataSize,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [31:0]       D,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_REQ,
    input  logic [7:0]        MEM_DATA,
    input  logic              MEM_ACK
);

    // RAM handshake: MEM_REQ is high for every REQ cycle with MEM_ADDR held;
    // a byte is taken on any REQ cycle where MEM_ACK is high, and MEM_ACK is
    // ignored in every other state.

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        n_q, n_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       d_q, d_d;
    logic              err_q, err_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            shift_q <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            d_q     <= d_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        shift_d = shift_q;
        d_d     = d_q;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (is_misaligned(dataSize, ADDR[1:0])) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = ADDR;
                        n_d     = size_bytes(dataSize);
                        cnt_d   = 3'd0;
                        shift_d = 32'h0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (MEM_ACK) begin
                    shift_d = {shift_q[23:0], MEM_DATA};
                    cnt_d   = cnt_q + 3'd1;
                    // D is loaded on the edge into FIN so it already holds the last byte.
                    if (cnt_d == n_q) begin
                        d_d     = shift_d;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = ST_REQ;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign BUSY     = (state_q != ST_IDLE);
    assign DONE     = (state_q == ST_FIN);
    assign MEM_REQ  = (state_q == ST_REQ);
    assign ERR      = err_q;
    assign D        = d_q;
    assign MEM_ADDR = addr_q;

endmodule

// File: tb/tb_load_byte_assembler.sv
// Directed bench for load_byte_assembler with a small byte-RAM responder and
// an expected-data queue popped on each DONE.
module tb_load_byte_assembler;
    import load_byte_assembler_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [7:0]  ADDR = 8'h0;
    logic [1:0]  dataSize = 2'b00;
    logic        BUSY, DONE, ERR, MEM_REQ;
    logic [31:0] D;
    logic [7:0]  MEM_ADDR;
    logic [7:0]  MEM_DATA = 8'h0;
    logic        MEM_ACK = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          wait_states = 0;
    int          wcnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_d = 32'h0;

    load_byte_assembler #(.ADDR_W(8)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .ADDR     (ADDR),
        .dataSize (dataSize),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .D        (D),
        .MEM_ADDR (MEM_ADDR),
        .MEM_REQ  (MEM_REQ),
        .MEM_DATA (MEM_DATA),
        .MEM_ACK  (MEM_ACK)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] ram_rd(input logic [7:0] a);
        case (a)
            8'h10:   ram_rd = 8'hF0;
            8'h11:   ram_rd = 8'hE4;
            8'h12:   ram_rd = 8'h74;
            8'h13:   ram_rd = 8'h92;
            default: ram_rd = a ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] sign_ext(input logic [31:0] d, input logic [1:0] size);
        case (size)
            SIZE_BYTE: sign_ext = {{24{d[7]}}, d[7:0]};
            SIZE_HALF: sign_ext = {{16{d[15]}}, d[15:0]};
            default:   sign_ext = d;
        endcase
    endfunction

    // RAM responder: acknowledges after wait_states stall cycles of MEM_REQ.
    always @(negedge CLK) begin
        if (MEM_REQ === 1'b1) begin
            if (wcnt >= wait_states) begin
                MEM_ACK  = 1'b1;
                MEM_DATA = ram_rd(MEM_ADDR);
                wcnt     = 0;
            end else begin
                MEM_ACK  = 1'b0;
                MEM_DATA = 8'h00;
                wcnt     = wcnt + 1;
            end
        end else begin
            MEM_ACK  = 1'b0;
            MEM_DATA = 8'h00;
            wcnt     = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One aligned load; poke>0 pulses a conflicting START in that busy cycle.
    task automatic run_load(input logic [7:0] a, input logic [1:0] sz, input int waits,
                            input int exp_cyc, input logic [31:0] exp_d, input int poke);
        int          c;
        int          gaps;
        logic [31:0] e;
        wait_states = waits;
        @(negedge CLK);
        ADDR     = a;
        dataSize = sz;
        START    = 1'b1;
        exp_q.push_back(exp_d);
        @(posedge CLK);
        #1;
        START = 1'b0;
        c     = 1;
        gaps  = 0;
        while (DONE !== 1'b1 && c < 100) begin
            if (MEM_REQ === 1'b1) chk("mem_addr", {24'h0, MEM_ADDR}, {24'h0, 8'(a + gaps)});
            else if (BUSY === 1'b1) gaps++;
            if (c == poke) begin
                START    = 1'b1;
                ADDR     = 8'h13;
                dataSize = SIZE_BYTE;
            end else begin
                START = 1'b0;
            end
            @(posedge CLK);
            #1;
            c++;
        end
        START = 1'b0;
        chk("done_cycle", c, exp_cyc);
        e = exp_q.pop_front();
        chk("d_value", D, e);
        chk("busy_in_done", {31'h0, BUSY}, 32'h1);
        @(posedge CLK);
        #1;
        chk("idle_after_done", {31'h0, BUSY}, 32'h0);
        chk("done_one_pulse", {31'h0, DONE}, 32'h0);
        chk("d_held", D, e);
        last_d = e;
    endtask

    task automatic run_misaligned(input logic [7:0] a, input logic [1:0] sz);
        @(negedge CLK);
        ADDR     = a;
        dataSize = sz;
        START    = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        chk("err_pulse", {31'h0, ERR}, 32'h1);
        chk("err_no_req", {31'h0, MEM_REQ}, 32'h0);
        chk("err_no_busy", {31'h0, BUSY}, 32'h0);
        chk("err_d_kept", D, last_d);
        @(posedge CLK);
        #1;
        chk("err_cleared", {31'h0, ERR}, 32'h0);
        chk("err_no_req2", {31'h0, MEM_REQ}, 32'h0);
        chk("err_d_kept2", D, last_d);
    endtask

    initial begin
        logic saw_done;

        // Reset state
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_busy", {31'h0, BUSY}, 32'h0);
        chk("rst_done", {31'h0, DONE}, 32'h0);
        chk("rst_err", {31'h0, ERR}, 32'h0);
        chk("rst_req", {31'h0, MEM_REQ}, 32'h0);
        chk("rst_d", D, 32'h0);
        chk("rst_addr", {24'h0, MEM_ADDR}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // Zero-wait loads
        run_load(8'h10, SIZE_WORD, 0, 8, 32'hF0E47492, 0);
        run_load(8'h13, SIZE_BYTE, 0, 2, 32'h00000092, 0);
        chk("sext_byte", sign_ext(D, SIZE_BYTE), 32'hFFFFFF92);
        run_load(8'h12, SIZE_HALF, 0, 4, 32'h00007492, 0);
        chk("sext_half", sign_ext(D, SIZE_HALF), 32'h00007492);

        // Misaligned requests leave D alone
        run_misaligned(8'h11, SIZE_HALF);
        run_misaligned(8'h12, SIZE_WORD);
        run_misaligned(8'h11, SIZE_DWORD);

        // Wait states with an ignored START while busy
        run_load(8'h10, SIZE_WORD, 3, 20, 32'hF0E47492, 3);
        run_load(8'h10, SIZE_DWORD, 0, 8, 32'hF0E47492, 0);
        run_load(8'h20, SIZE_HALF, 1, 6, {16'h0, 8'h20 ^ 8'hA5, 8'h21 ^ 8'hA5}, 0);

        // Reset after two bytes of a word
        wait_states = 0;
        @(negedge CLK);
        ADDR     = 8'h10;
        dataSize = SIZE_WORD;
        START    = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        chk("mid_gap_busy", {31'h0, BUSY}, 32'h1);
        chk("mid_gap_req", {31'h0, MEM_REQ}, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("rstmid_req", {31'h0, MEM_REQ}, 32'h0);
        chk("rstmid_busy", {31'h0, BUSY}, 32'h0);
        chk("rstmid_d", D, 32'h0);
        chk("rstmid_done", {31'h0, DONE}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            if (DONE !== 1'b0 || MEM_REQ !== 1'b0) saw_done = 1'b1;
        end
        chk("rstmid_quiet", {31'h0, saw_done}, 32'h0);
        last_d = 32'h0;
        run_load(8'h10, SIZE_BYTE, 0, 2, 32'h000000F0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
